// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for one shared byte-wide request/data-valid peripheral port.
// Keeps one slave transaction outstanding at a time, routes read data back, and times out a silent slave.
module periph_bus_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_request,
  input  logic [ADDR_W-1:0] i_m0_address,
  input  logic [DATA_W-1:0] i_m0_data,
  input  logic              i_m0_write,
  output logic [DATA_W-1:0] o_m0_data,
  output logic              o_m0_data_DV,
  input  logic              i_m1_request,
  input  logic [ADDR_W-1:0] i_m1_address,
  input  logic [DATA_W-1:0] i_m1_data,
  input  logic              i_m1_write,
  output logic [DATA_W-1:0] o_m1_data,
  output logic              o_m1_data_DV,
  output logic              o_s_request,
  output logic [ADDR_W-1:0] o_s_address,
  output logic [DATA_W-1:0] o_s_data,
  output logic              o_s_write,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_data_DV,
  output logic              o_timeout
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant, grant_nxt;
  logic             take;
  logic [CNT_W-1:0] cnt;
  logic             to_flag;
  logic             cnt_done;

  assign cnt_done = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (i_m0_request && i_m1_request) begin
          take      = 1'b1;
          grant_nxt = ~last_grant;
        end else if (i_m0_request) begin
          take      = 1'b1;
          grant_nxt = 1'b0;
        end else if (i_m1_request) begin
          take      = 1'b1;
          grant_nxt = 1'b1;
        end
        if (take) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (i_s_data_DV || cnt_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      cnt         <= '0;
      to_flag     <= 1'b0;
      o_s_address <= '0;
      o_s_data    <= '0;
      o_s_write   <= 1'b0;
      o_m0_data   <= '0;
      o_m1_data   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (take) begin
            grant       <= grant_nxt;
            o_s_address <= grant_nxt ? i_m1_address : i_m0_address;
            o_s_data    <= grant_nxt ? i_m1_data    : i_m0_data;
            o_s_write   <= grant_nxt ? i_m1_write   : i_m0_write;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          // Slave data wins over a timeout landing on the same cycle.
          if (i_s_data_DV) begin
            if (grant) o_m1_data <= i_s_data;
            else       o_m0_data <= i_s_data;
          end else if (cnt_done) begin
            if (grant) o_m1_data <= '0;
            else       o_m0_data <= '0;
            to_flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          last_grant <= grant;
          to_flag    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_s_request  = (state == ISSUE);
  assign o_m0_data_DV = (state == RESP) && !grant;
  assign o_m1_data_DV = (state == RESP) &&  grant;
  assign o_timeout    = (state == RESP) &&  to_flag;

endmodule
